// File: rtl/int_cfg_arbiter.sv
// int_cfg_arbiter: programs default interrupt vectors/mask after reset, then arbitrates MMIO onto the controller config port
module int_cfg_arbiter #(
  parameter int INTERRUPT_LINES = 16,
  parameter int INTERRUPT_BITS = $clog2(INTERRUPT_LINES),
  parameter logic [31:0] VEC_BASE = 32'h0000_1000,
  parameter logic [31:0] VEC_STRIDE = 32'h0000_0040,
  parameter logic [INTERRUPT_LINES-1:0] RESET_MASK = '1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic reinit,
  output logic init_done,
  input  logic bus_req,
  input  logic bus_we,
  input  logic bus_sel_mask,
  input  logic [INTERRUPT_BITS-1:0] bus_entry_id,
  input  logic [31:0] bus_wdata,
  output logic bus_ack,
  output logic bus_rvalid,
  output logic [31:0] bus_rdata,
  input  logic in_service,
  output logic update_int_vec_table,
  output logic read_vec_table,
  output logic [INTERRUPT_BITS-1:0] table_entry_id,
  output logic [31:0] wdata_vec_table,
  input  logic [31:0] int_vec_table_pc,
  output logic update_int_mask,
  output logic read_mask,
  output logic [INTERRUPT_LINES-1:0] wdata_int_mask,
  input  logic [INTERRUPT_LINES-1:0] int_mask_val
);
  typedef enum logic [1:0] {INIT_VEC, INIT_MASK, IDLE} state_t;
  state_t state_q, state_d;
  logic [INTERRUPT_BITS-1:0] cnt_q, cnt_d;
  logic rvalid_q, accept, rd_acc;
  logic [31:0] rdata_q, rdata_d;
  assign init_done = state_q == IDLE;
  assign bus_rvalid = rvalid_q;
  assign bus_rdata = rdata_q;
  // vector-table writes stall while the controller is presenting a PC
  assign accept = state_q == IDLE && bus_req && !reinit && !(bus_we && !bus_sel_mask && in_service);
  assign rd_acc = accept && !bus_we;
  assign rdata_d = bus_sel_mask ? 32'(int_mask_val) : int_vec_table_pc;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    bus_ack = 1'b0;
    update_int_vec_table = 1'b0;
    read_vec_table = 1'b0;
    update_int_mask = 1'b0;
    read_mask = 1'b0;
    table_entry_id = '0;
    wdata_vec_table = '0;
    wdata_int_mask = '0;
    case (state_q)
      INIT_VEC: begin
        // init strobes are gated by rst_n so nothing reaches the controller while in reset
        update_int_vec_table = rst_n;
        table_entry_id = rst_n ? cnt_q : '0;
        wdata_vec_table = rst_n ? VEC_BASE + 32'(cnt_q) * VEC_STRIDE : '0;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == INTERRUPT_BITS'(INTERRUPT_LINES - 1)) begin
          state_d = INIT_MASK;
          cnt_d = '0;
        end
      end
      INIT_MASK: begin
        update_int_mask = rst_n;
        wdata_int_mask = rst_n ? RESET_MASK : '0;
        state_d = IDLE;
      end
      IDLE: begin
        state_d = reinit ? INIT_VEC : IDLE;
        bus_ack = accept;
        update_int_vec_table = accept && bus_we && !bus_sel_mask;
        read_vec_table = accept && !bus_we && !bus_sel_mask;
        update_int_mask = accept && bus_we && bus_sel_mask;
        read_mask = accept && !bus_we && bus_sel_mask;
        table_entry_id = accept && !bus_sel_mask ? bus_entry_id : '0;
        wdata_vec_table = update_int_vec_table ? bus_wdata : '0;
        wdata_int_mask = update_int_mask ? bus_wdata[INTERRUPT_LINES-1:0] : '0;
      end
      default: state_d = INIT_VEC;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= INIT_VEC;
      cnt_q <= '0;
      rvalid_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      rvalid_q <= rd_acc;
      if (rd_acc) rdata_q <= rdata_d;
    end
  end
endmodule

// File: tb/tb_int_cfg_arbiter.sv
// tb_int_cfg_arbiter: directed and randomized checks of int_cfg_arbiter against a table/mask reference model
module tb_int_cfg_arbiter;
  logic clk = 1'b0, rst_n = 1'b0, reinit = 1'b0;
  logic init_done, bus_req = 1'b0, bus_we = 1'b0, bus_sel_mask = 1'b0;
  logic [3:0] bus_entry_id = '0;
  logic [31:0] bus_wdata = '0;
  logic bus_ack, bus_rvalid;
  logic [31:0] bus_rdata;
  logic in_service = 1'b0;
  logic update_int_vec_table, read_vec_table, update_int_mask, read_mask;
  logic [3:0] table_entry_id;
  logic [31:0] wdata_vec_table, int_vec_table_pc;
  logic [15:0] wdata_int_mask, int_mask_val;
  logic [31:0] ctl_tab[16];
  logic [15:0] ctl_mask;
  logic [31:0] exp_tab[16];
  logic [15:0] exp_mask;
  logic [3:0] strb;
  int passed = 0, total = 0, fails = 0;
  int w;
  int_cfg_arbiter dut (
    .clk(clk), .rst_n(rst_n), .reinit(reinit), .init_done(init_done),
    .bus_req(bus_req), .bus_we(bus_we), .bus_sel_mask(bus_sel_mask),
    .bus_entry_id(bus_entry_id), .bus_wdata(bus_wdata), .bus_ack(bus_ack),
    .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata), .in_service(in_service),
    .update_int_vec_table(update_int_vec_table), .read_vec_table(read_vec_table),
    .table_entry_id(table_entry_id), .wdata_vec_table(wdata_vec_table),
    .int_vec_table_pc(int_vec_table_pc), .update_int_mask(update_int_mask),
    .read_mask(read_mask), .wdata_int_mask(wdata_int_mask), .int_mask_val(int_mask_val)
  );
  always #5 clk = ~clk;
  // stand-in for the interrupt controller's config storage
  always @(posedge clk) begin
    if (update_int_vec_table) ctl_tab[table_entry_id] <= wdata_vec_table;
    if (update_int_mask) ctl_mask <= wdata_int_mask;
  end
  assign int_vec_table_pc = ctl_tab[table_entry_id];
  assign int_mask_val = ctl_mask;
  assign strb = {update_int_vec_table, read_vec_table, update_int_mask, read_mask};
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end
  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    total++;
    assert (o === e) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask
  task automatic set_defaults();
    for (int i = 0; i < 16; i++) exp_tab[i] = 32'h1000 + 32'(i) * 32'd64;
    exp_mask = 16'hFFFF;
  endtask
  task automatic chk_reset_outputs();
    chk("rst_strobes", 32'(strb), 32'd0);
    chk("rst_init_done", 32'(init_done), 32'd0);
    chk("rst_ack", 32'(bus_ack), 32'd0);
    chk("rst_rvalid", 32'(bus_rvalid), 32'd0);
    chk("rst_rdata", bus_rdata, 32'd0);
  endtask
  // called at the negedge where the DUT sits in INIT_VEC with entry 0
  task automatic check_init();
    set_defaults();
    for (int k = 0; k < 16; k++) begin
      #1;
      chk($sformatf("init_strb%0d", k), 32'(strb), 32'h8);
      chk($sformatf("init_id%0d", k), 32'(table_entry_id), 32'(k));
      chk($sformatf("init_data%0d", k), wdata_vec_table, exp_tab[k]);
      chk($sformatf("init_ack%0d", k), 32'(bus_ack), 32'd0);
      chk($sformatf("init_done_lo%0d", k), 32'(init_done), 32'd0);
      @(negedge clk);
    end
    #1;
    chk("init_mask_strb", 32'(strb), 32'h2);
    chk("init_mask_data", 32'(wdata_int_mask), 32'(exp_mask));
    chk("init_mask_ack", 32'(bus_ack), 32'd0);
    @(negedge clk);
    chk("init_done_c17", 32'(init_done), 32'd1);
    for (int i = 0; i < 16; i++) chk($sformatf("ctl_tab%0d", i), ctl_tab[i], exp_tab[i]);
    chk("ctl_mask", 32'(ctl_mask), 32'(exp_mask));
  endtask
  task automatic do_op(input logic we, input logic sel, input logic [3:0] id, input logic [31:0] d, output int waited);
    logic [31:0] er;
    logic [3:0] es;
    bus_req = 1'b1; bus_we = we; bus_sel_mask = sel; bus_entry_id = id; bus_wdata = d;
    waited = 0;
    #1;
    while (!bus_ack && waited < 50) begin
      @(negedge clk);
      #1;
      waited++;
    end
    chk("ack", 32'(bus_ack), 32'd1);
    es = we ? (sel ? 4'b0010 : 4'b1000) : (sel ? 4'b0001 : 4'b0100);
    chk("strobe", 32'(strb), 32'(es));
    if (!sel) chk("entry_id", 32'(table_entry_id), 32'(id));
    if (we && !sel) chk("wdata_vec", wdata_vec_table, d);
    if (we && sel) chk("wdata_mask", 32'(wdata_int_mask), 32'(d[15:0]));
    er = sel ? {16'h0, exp_mask} : exp_tab[id];
    if (we && sel) exp_mask = d[15:0];
    if (we && !sel) exp_tab[id] = d;
    @(negedge clk);
    bus_req = 1'b0; bus_we = 1'b0; bus_sel_mask = 1'b0; bus_entry_id = '0; bus_wdata = '0;
    chk("rvalid", 32'(bus_rvalid), 32'(!we));
    if (!we) chk("rdata", bus_rdata, er);
  endtask
  initial begin
    logic we, sel;
    logic [3:0] id;
    logic [31:0] d;
    #1;
    chk_reset_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    check_init();
    // read of entry 5 pending across reset and init
    rst_n = 1'b0;
    bus_req = 1'b1; bus_entry_id = 4'd5;
    #1;
    chk_reset_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    check_init();
    do_op(1'b0, 1'b0, 4'd5, 32'd0, w);
    chk("pending_read_first_idle", 32'(w), 32'd0);
    chk("read5_value", bus_rdata, 32'h0000_1140);
    // vector write held by in_service
    in_service = 1'b1;
    bus_req = 1'b1; bus_we = 1'b1; bus_sel_mask = 1'b0; bus_entry_id = 4'd3; bus_wdata = 32'hDEAD_BEEF;
    for (int k = 0; k < 10; k++) begin
      #1;
      chk("held_ack", 32'(bus_ack), 32'd0);
      chk("held_strb", 32'(strb), 32'd0);
      @(negedge clk);
    end
    in_service = 1'b0;
    do_op(1'b1, 1'b0, 4'd3, 32'hDEAD_BEEF, w);
    chk("held_release_same_cycle", 32'(w), 32'd0);
    in_service = 1'b1;
    do_op(1'b1, 1'b1, 4'd0, 32'h0000_00FF, w);
    chk("mask_not_held", 32'(w), 32'd0);
    do_op(1'b0, 1'b0, 4'd3, 32'd0, w);
    chk("read_not_held", 32'(w), 32'd0);
    in_service = 1'b0;
    do_op(1'b1, 1'b1, 4'd0, 32'hFFFF_00A5, w);
    do_op(1'b0, 1'b1, 4'd0, 32'd0, w);
    chk("mask_read_zext", bus_rdata, 32'h0000_00A5);
    // randomized traffic
    repeat (150) begin
      we = 1'($urandom); sel = 1'($urandom); id = 4'($urandom); d = $urandom;
      in_service = $urandom_range(0, 3) == 0;
      if (in_service && we && !sel) begin
        bus_req = 1'b1; bus_we = we; bus_sel_mask = sel; bus_entry_id = id; bus_wdata = d;
        #1;
        chk("rnd_held_ack", 32'(bus_ack), 32'd0);
        @(negedge clk);
        in_service = 1'b0;
      end
      do_op(we, sel, id, d, w);
      chk("rnd_wait", 32'(w), 32'd0);
      in_service = 1'b0;
    end
    for (int i = 0; i < 16; i++) chk($sformatf("rnd_ctl_tab%0d", i), ctl_tab[i], exp_tab[i]);
    chk("rnd_ctl_mask", 32'(ctl_mask), 32'(exp_mask));
    // reinit wins over a simultaneous read, which then sees defaults
    do_op(1'b1, 1'b0, 4'd3, 32'h1234_5678, w);
    bus_req = 1'b1; bus_we = 1'b0; bus_sel_mask = 1'b0; bus_entry_id = 4'd3;
    reinit = 1'b1;
    #1;
    chk("reinit_no_ack", 32'(bus_ack), 32'd0);
    chk("reinit_strb", 32'(strb), 32'd0);
    @(negedge clk);
    reinit = 1'b0;
    chk("reinit_done_drop", 32'(init_done), 32'd0);
    check_init();
    do_op(1'b0, 1'b0, 4'd3, 32'd0, w);
    chk("reinit_read_wait", 32'(w), 32'd0);
    chk("reinit_default3", bus_rdata, 32'h0000_10C0);
    // reinit ignored during init
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      reinit = k == 4;
      @(negedge clk);
    end
    reinit = 1'b0;
    #1;
    chk("mid_init_id8", 32'(table_entry_id), 32'd8);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    check_init();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/int_cfg_arbiter.md
# int_cfg_arbiter

Sits between the memory-bus MMIO decode and the configuration port of the interrupt controller, which holds the vector table and the mask. After reset it autonomously programs a default vector table and mask. It then arbitrates MMIO read/write requests onto the single configuration port. Vector-table writes are held off while an interrupt is in service, so the PC being presented to the core cannot change under it.

## Interface
- INTERRUPT_LINES, 16, number of interrupt lines and vector-table entries
- INTERRUPT_BITS, $clog2(INTERRUPT_LINES), entry index width
- VEC_BASE, 32'h0000_1000, default vector of entry 0
- VEC_STRIDE, 32'h0000_0040, address step between default vectors
- RESET_MASK, '1 (all lines enabled), mask value written at the end of init

Ports:
- clk  in  1  clock; single clock domain
- rst_n  in  1  asynchronous, active-low reset
- reinit  in  1  one-cycle pulse; restarts the default-programming sequence
- init_done  out  1  high once defaults are written and the bus is being served
- bus_req  in  1  MMIO request; held stable until bus_ack
- bus_we  in  1  1 = write, 0 = read
- bus_sel_mask  in  1  1 = mask register, 0 = vector-table entry
- bus_entry_id  in  INTERRUPT_BITS  vector-table index (ignored when bus_sel_mask=1)
- bus_wdata  in  32  write data; mask uses bits [INTERRUPT_LINES-1:0]
- bus_ack  out  1  one-cycle pulse; request accepted
- bus_rvalid  out  1  one-cycle pulse; bus_rdata valid
- bus_rdata  out  32  read data; mask reads are zero-extended
- in_service  in  1  from interrupt controller; an interrupt is in progress
- update_int_vec_table, read_vec_table  out  1  controller table write/read strobes
- table_entry_id  out  INTERRUPT_BITS  controller table index
- wdata_vec_table  out  32  controller table write data
- int_vec_table_pc  in  32  controller table read data (combinational, valid when read_vec_table=1)
- update_int_mask, read_mask  out  1  controller mask write/read strobes
- wdata_int_mask  out  INTERRUPT_LINES  controller mask write data
- int_mask_val  in  INTERRUPT_LINES  controller mask read data (combinational)

## Operation
- States: INIT_VEC, INIT_MASK, IDLE. A 2-bit encoding is sufficient.
- Reset (rst_n low, asynchronous):
  - state=INIT_VEC, entry counter=0.
  - All outputs 0: init_done, bus_ack, bus_rvalid, bus_rdata and every controller strobe.
- INIT_VEC:
  - Each cycle: update_int_vec_table=1, table_entry_id=cnt, wdata_vec_table=VEC_BASE+cnt*VEC_STRIDE. The sum is computed in 32 bits and truncated mod 2^32.
  - cnt increments each cycle. At cnt=INTERRUPT_LINES-1 the next state is INIT_MASK and cnt clears.
- INIT_MASK:
  - One cycle: update_int_mask=1, wdata_int_mask=RESET_MASK.
  - Next state is IDLE; init_done is registered high on entry to IDLE.
- IDLE serves bus requests:
  - Accept when bus_req=1 and not (bus_we=1 and bus_sel_mask=0 and in_service=1).
  - On accept, in the same cycle: drive exactly one controller strobe per bus_we/bus_sel_mask, with table_entry_id=bus_entry_id and write data passed straight through; bus_ack=1.
  - Read accept: capture int_vec_table_pc or zero-extended int_mask_val into bus_rdata; bus_rvalid=1 the next cycle.
- Held writes:
  - A vector-table write while in_service=1 gets no ack and no strobe; it stays pending until in_service drops, then is accepted that cycle.
  - Mask writes and all reads are never held.
- bus_req during INIT_*: ignored, no ack. It is served in the first IDLE cycle.
- reinit:
  - Sampled in IDLE only; ignored in INIT_* states.
  - If reinit and an acceptable bus_req occur in the same cycle, reinit wins and the request waits.
  - Next state is INIT_VEC with cnt=0; init_done drops the same edge.
- Strobes are mutually exclusive every cycle; table strobes are never asserted together with mask strobes.
- Outside an accept or init write, wdata/table_entry_id outputs are 0.

## Timing
- Init latency: INTERRUPT_LINES+1 cycles after rst_n deasserts; with the 16-line default, init_done=1 from cycle 17 (counting the first post-reset edge as 1).
- Write: ack and controller strobe in the same cycle (accept cycle T); the controller updates at edge T+1.
- Read: ack at T; bus_rvalid and bus_rdata at T+1. bus_rdata holds until the next read.
- Throughput: one request per cycle in IDLE. The requester must drop or change bus_req after bus_ack, or it is accepted again.
- Reset mid-init or mid-read: asynchronous clear, bus_rvalid is lost, init restarts from entry 0.

## Test plan
- Reset release, no bus traffic → 16 table writes with ids 0..15, data 0x1000, 0x1040 … 0x13C0; then mask write 0xFFFF; init_done high at cycle 17.
- bus_req read entry 5 held from reset → no ack before IDLE; ack in the first IDLE cycle; bus_rvalid next cycle with bus_rdata=0x1140.
- in_service=1, write entry 3 = 0xDEAD_BEEF → no ack for 10 cycles; drop in_service → ack and update_int_vec_table with id 3 the same cycle. Mask write 0x00FF during in_service → acked immediately.
- Mask read after writing 0x00A5 → bus_rdata=0x0000_00A5, upper bits zero.
- reinit together with a pending read → init_done falls, 17-cycle reprogram, then read acked. Table entries previously overwritten return defaults.
- rst_n pulse at init cycle 8 → all outputs 0 immediately; sequence restarts at id 0.
